// File: rtl/codec_init_seq.sv
// codec_init_seq: pushes a fixed table of 16-bit codec setup words
// through an i2c master, with per-word retries, inter-word gap and timeout.
module codec_init_seq #(
    parameter int NUM_WORDS      = 10,
    parameter int MAX_RETRY      = 3,
    parameter int GAP_CYCLES     = 50000,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        txdone,
    input  logic        ackOK,
    output logic        trig,
    output logic [15:0] data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [3:0]  wordIdx
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_TRIG  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;
    localparam logic [2:0] S_ERROR = 3'd7;

    // Counters only ever hold 0..limit-1 (or 0..MAX_RETRY), so they cannot wrap.
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [GW-1:0] G_LAST   = GW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] R_MAX    = RW'(MAX_RETRY);
    localparam logic [3:0]    LAST_IDX = 4'(NUM_WORDS - 1);

    logic [2:0]    state;
    logic [GW-1:0] gcnt;
    logic [TW-1:0] tcnt;
    logic [RW-1:0] rcnt;
    logic          ack_q;

    function automatic logic [15:0] rom(input logic [3:0] i);
        case (i)
            4'd0:    rom = 16'h1E00;
            4'd1:    rom = 16'h0C10;
            4'd2:    rom = 16'h0017;
            4'd3:    rom = 16'h0217;
            4'd4:    rom = 16'h0479;
            4'd5:    rom = 16'h0679;
            4'd6:    rom = 16'h0812;
            4'd7:    rom = 16'h0A00;
            4'd8:    rom = 16'h0E01;
            4'd9:    rom = 16'h1201;
            default: rom = 16'h0000;
        endcase
    endfunction

    // Sequencer: load word, request transfer, await result, retry or advance.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= S_IDLE;
            trig    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            data    <= 16'h0000;
            wordIdx <= 4'd0;
            gcnt    <= '0;
            tcnt    <= '0;
            rcnt    <= '0;
            ack_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state   <= S_LOAD;
                        wordIdx <= 4'd0;
                        rcnt    <= '0;
                        done    <= 1'b0;
                        err     <= 1'b0;
                    end
                end
                S_LOAD: begin
                    data <= rom(wordIdx);
                    if (txdone) begin
                        state <= S_TRIG;
                        trig  <= 1'b1;
                        tcnt  <= '0;
                    end
                end
                S_TRIG: begin
                    if (!txdone) begin
                        state <= S_WAIT;
                        trig  <= 1'b0;
                        tcnt  <= '0;
                    end else if (tcnt == T_LAST) begin
                        state <= S_CHECK;
                        trig  <= 1'b0;
                        ack_q <= 1'b0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (txdone) begin
                        state <= S_CHECK;
                        ack_q <= ackOK;
                    end else if (tcnt == T_LAST) begin
                        state <= S_CHECK;
                        ack_q <= 1'b0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    gcnt <= '0;
                    if (ack_q) begin
                        if (wordIdx == LAST_IDX) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= S_GAP;
                            wordIdx <= wordIdx + 4'd1;
                            rcnt    <= '0;
                        end
                    end else if (rcnt == R_MAX) begin
                        state <= S_ERROR;
                        err   <= 1'b1;
                    end else begin
                        state <= S_GAP;
                        rcnt  <= rcnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (gcnt == G_LAST) begin
                        state <= S_LOAD;
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_LOAD) || (state == S_TRIG) ||
                  (state == S_WAIT) || (state == S_CHECK) ||
                  (state == S_GAP);

endmodule
